// File: rtl/ser_pkg.sv
// ser_pkg: state encodings and default width for bit_serializer.
// The PAR state exists only when SER_PARITY_EN is defined.
package ser_pkg;

    localparam int SER_DATA_W_DEF = 8;

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_PAR   = 2'b10
    } ser_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01
    } ser_state_t;
`endif

endpackage

// File: rtl/ser_hold_reg.sv
// ser_hold_reg: one-word holding register in front of the shifter.
// A word is taken on data_valid && data_ready; load empties the slot when
// the shifter takes the word. Accept sets the flag, load clears it.
module ser_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              load,
    output logic [DATA_W-1:0] hold_data,
    output logic              hold_full,
    output logic              data_ready
);

    logic [DATA_W-1:0] hold_q, hold_d;
    logic              full_q, full_d;
    logic              accept;

    assign data_ready = !full_q;
    assign accept     = data_valid && data_ready;
    assign hold_data  = hold_q;
    assign hold_full  = full_q;

    // Next slot contents: load clears first, a new accept then sets.
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (load) full_d = 1'b0;
        if (accept) begin
            hold_d = data_in;
            full_d = 1'b1;
        end
    end

    // Slot registers; reset discards any held word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end, MSB first, one bit per clock,
// registered outputs, zero-gap streaming from a one-word holding register.
// Optional: define SER_PARITY_EN to append an even-parity bit to each frame.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W = SER_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    // cnt is one bit wider so the "all bits presented" value fits without wrap.
    localparam logic [CNT_W:0] CNT_LAST = (CNT_W+1)'(DATA_W);
`ifndef SER_PARITY_EN
    localparam logic [CNT_W:0] CNT_PEN  = (CNT_W+1)'(DATA_W-1);
`endif

    ser_state_t        state_q, state_d;
    logic [CNT_W:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              bit_out_q, bit_out_d;
    logic              bit_valid_q, bit_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              load, end_frame;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;
    logic [CNT_W-1:0]  idx;

    ser_hold_reg #(.DATA_W(DATA_W)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .load       (load),
        .hold_data  (hold_data),
        .hold_full  (hold_full),
        .data_ready (data_ready)
    );

    // Bit position presented next; the word stays intact in sreg (needed for parity).
    assign idx = CNT_W'(DATA_W-1) - cnt_q[CNT_W-1:0];

    // FSM, counter and output bit selection.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sreg_d       = sreg_q;
        bit_out_d    = 1'b0;
        bit_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        load         = 1'b0;
        end_frame    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_full) load = 1'b1;
            end
            ST_SHIFT: begin
                if (cnt_q < CNT_LAST) begin
                    bit_out_d   = sreg_q[idx];
                    bit_valid_d = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
`ifndef SER_PARITY_EN
                    frame_done_d = (cnt_q == CNT_PEN);
`endif
                end else begin
`ifdef SER_PARITY_EN
                    state_d      = ST_PAR;
                    bit_out_d    = ^sreg_q;
                    bit_valid_d  = 1'b1;
                    frame_done_d = 1'b1;
`else
                    end_frame = 1'b1;
`endif
                end
            end
`ifdef SER_PARITY_EN
            ST_PAR: begin
                end_frame = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // End of frame: chain straight into the held word, else go idle.
        if (end_frame) begin
            if (hold_full) load = 1'b1;
            else           state_d = ST_IDLE;
        end

        // Load presents the MSB on the same edge, so no idle gap between words.
        if (load) begin
            sreg_d      = hold_data;
            bit_out_d   = hold_data[DATA_W-1];
            bit_valid_d = 1'b1;
            cnt_d       = (CNT_W+1)'(1);
            state_d     = ST_SHIFT;
        end
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sreg_q       <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE) || hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: table vectors, hand-written corner sequences and a
// randomized run against a queue-based transaction model.
`timescale 1ns/1ps
module tb_bit_serializer;

    localparam int DATA_W = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME = DATA_W + 1;
`else
    localparam int FRAME = DATA_W;
`endif

    typedef struct {
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] exp_bits;  // expected stream, first-sent bit on the left
        logic              exp_par;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready, bit_out, bit_valid, frame_done, busy;

    int checks = 0;
    int errors = 0;

    // Model: words accepted but not yet started, and bits of the frame on the wire.
    logic [DATA_W-1:0] pend_q[$];
    bit                cur_q[$];

    vec_t              vecs[8];
    logic [DATA_W-1:0] ws[3];
    logic [DATA_W-1:0] eb_vec;

    bit_serializer #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the model: continue the current frame, else start a
    // waiting word; a word accepted on this edge only waits.
    task automatic model_step(input bit acc, output bit ev, output bit eb, output bit ed);
        logic [DATA_W-1:0] w;
        ev = 1'b0; eb = 1'b0; ed = 1'b0;
        if (cur_q.size() == 0 && pend_q.size() != 0) begin
            w = pend_q.pop_front();
            for (int i = DATA_W-1; i >= 0; i--) cur_q.push_back(w[i]);
`ifdef SER_PARITY_EN
            cur_q.push_back(^w);
`endif
        end
        if (cur_q.size() != 0) begin
            ev = 1'b1;
            eb = cur_q.pop_front();
            ed = (cur_q.size() == 0);
        end
        if (acc) pend_q.push_back(data_in);
    endtask

    // One checked cycle: accept decided by the model's own ready.
    task automatic cyc(output bit acc);
        bit ev, eb, ed;
        acc = data_valid && (pend_q.size() == 0);
        @(posedge clk); #1;
        model_step(acc, ev, eb, ed);
        chk("bit_valid",  bit_valid,  ev);
        chk("bit_out",    bit_out,    eb);
        chk("frame_done", frame_done, ed);
        chk("data_ready", data_ready, pend_q.size() == 0);
        chk("busy",       busy,       ev || (pend_q.size() != 0));
    endtask

    initial begin
        bit acc;
        int idx, run, maxrun, frames;
        logic exp_b;

        vecs[0] = '{8'h99, 8'b10011001, 1'b0};
        vecs[1] = '{8'hA5, 8'b10100101, 1'b0};
        vecs[2] = '{8'h07, 8'b00000111, 1'b1};
        vecs[3] = '{8'h80, 8'b10000000, 1'b1};
        vecs[4] = '{8'h01, 8'b00000001, 1'b1};
        vecs[5] = '{8'h00, 8'b00000000, 1'b0};
        vecs[6] = '{8'hFF, 8'b11111111, 1'b0};
        vecs[7] = '{8'h6E, 8'b01101110, 1'b1};

        // Reset held with data_valid high: nothing may be accepted.
        rst = 1'b0; data_valid = 1'b1; data_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bit_out", bit_out, 0);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_data_ready", data_ready, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b1; data_valid = 1'b0;
        chk("rel_data_ready", data_ready, 1);
        repeat (3) cyc(acc);

        // Table: single words, exact latency, bit order, frame_done placement.
        foreach (vecs[v]) begin
            data_in = vecs[v].word; data_valid = 1'b1;
            @(posedge clk); #1;
            data_valid = 1'b0; data_in = ~vecs[v].word;
            chk($sformatf("v%0d_t0_valid", v), bit_valid, 0);
            chk($sformatf("v%0d_t0_ready", v), data_ready, 0);
            eb_vec = vecs[v].exp_bits;
            for (int i = 0; i < FRAME; i++) begin
                @(posedge clk); #1;
                exp_b = (i < DATA_W) ? eb_vec[DATA_W-1-i] : vecs[v].exp_par;
                chk($sformatf("v%0d_b%0d_valid", v, i), bit_valid, 1);
                chk($sformatf("v%0d_b%0d_bit", v, i), bit_out, exp_b);
                chk($sformatf("v%0d_b%0d_done", v, i), frame_done, i == FRAME-1);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_end_valid", v), bit_valid, 0);
            chk($sformatf("v%0d_end_bit", v), bit_out, 0);
            chk($sformatf("v%0d_end_busy", v), busy, 0);
        end

        // Two words offered back to back: one unbroken run of bits.
        ws[0] = 8'hF0; ws[1] = 8'h0F;
        idx = 0; run = 0; maxrun = 0;
        data_in = ws[0]; data_valid = 1'b1;
        for (int c = 0; c < 3*FRAME+6; c++) begin
            cyc(acc);
            if (acc) begin
                idx++;
                if (idx < 2) data_in = ws[idx]; else data_valid = 1'b0;
            end
            if (bit_valid) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else run = 0;
        end
        chk("stream_run", maxrun, 2*FRAME);
        chk("stream_acc", idx, 2);

        // Third word held valid while the slot is full: sent exactly once.
        ws[0] = 8'h3C; ws[1] = 8'hC3; ws[2] = 8'h5A;
        idx = 0; frames = 0;
        data_in = ws[0]; data_valid = 1'b1;
        for (int c = 0; c < 4*FRAME+8; c++) begin
            cyc(acc);
            if (acc) begin
                idx++;
                if (idx < 3) data_in = ws[idx]; else data_valid = 1'b0;
            end
            if (frame_done) frames++;
        end
        chk("held_frames", frames, 3);
        chk("held_acc", idx, 3);

        // Reset at the 4th bit of A5 with another word held.
        data_in = 8'hA5; data_valid = 1'b1;
        cyc(acc);
        data_in = 8'h11;
        for (int c = 0; c < 4; c++) begin
            cyc(acc);
            if (acc) data_valid = 1'b0;
        end
        data_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_bit_valid", bit_valid, 0);
        chk("arst_bit_out", bit_out, 0);
        chk("arst_frame_done", frame_done, 0);
        chk("arst_data_ready", data_ready, 1);
        chk("arst_busy", busy, 0);
        pend_q.delete(); cur_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) cyc(acc);
        data_in = 8'h3C; data_valid = 1'b1;
        cyc(acc);
        data_valid = 1'b0;
        repeat (FRAME+3) cyc(acc);

        // Randomized traffic with phases of sparse and dense offers.
        for (int c = 0; c < 900; c++) begin
            if (!data_valid && $urandom_range(0, (c/150)%3 + 1) != 0) begin
                data_valid = 1'b1;
                data_in = DATA_W'($urandom);
            end
            cyc(acc);
            if (acc) data_valid = 1'b0;
        end
        data_valid = 1'b0;
        repeat (2*FRAME+4) cyc(acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
